// File: rtl/computer.sv
// Single-cycle 8-bit accumulator computer: PC, 256-word instruction ROM, registers A/B and ALU.
// One instruction retires per rising clk edge; reset is synchronous and active-low.

module computer_register #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [DATA_W-1:0] i_d,
   output logic [DATA_W-1:0] out
);

   logic [DATA_W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_we) begin
         r_q <= i_d;
      end
   end

   assign out = r_q;

endmodule

module computer_imem #(
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 15
) (
   input  logic [PC_W-1:0]    i_addr,
   output logic [INSTR_W-1:0] o_instr
);

   // Contents are preloaded from outside by the bench.
   logic [INSTR_W-1:0] mem [0:(2**PC_W)-1];

   assign o_instr = mem[i_addr];

endmodule

module computer #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned PC_W    = 8,
   parameter int unsigned INSTR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [DATA_W-1:0] a_out,
   output logic [DATA_W-1:0] b_out,
   output logic [PC_W-1:0]   pc_out
);

   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] w_instr;
   logic [6:0]         w_op;
   logic [DATA_W-1:0]  w_lit;
   logic [4:0]         w_grp;
   logic [1:0]         w_sel;
   logic [DATA_W-1:0]  w_a;
   logic [DATA_W-1:0]  w_b;
   logic [DATA_W-1:0]  w_x;
   logic [DATA_W-1:0]  w_y;
   logic [DATA_W-1:0]  w_u;
   logic [DATA_W-1:0]  w_res;
   logic               w_we_a;
   logic               w_we_b;

   computer_imem #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) IM (
      .i_addr  (r_pc),
      .o_instr (w_instr)
   );

   computer_register #(
      .DATA_W (DATA_W)
   ) regA (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we_a),
      .i_d   (w_res),
      .out   (w_a)
   );

   computer_register #(
      .DATA_W (DATA_W)
   ) regB (
      .clk   (clk),
      .rst_n (rst_n),
      .i_we  (w_we_b),
      .i_d   (w_res),
      .out   (w_b)
   );

   assign w_op  = w_instr[14:8];
   assign w_lit = w_instr[7:0];
   assign w_grp = w_op[6:2];
   assign w_sel = w_op[1:0];

   // Binary groups: sel[0] picks destination (and first operand), sel[1] picks literal.
   assign w_x = w_sel[0] ? w_b : w_a;
   assign w_y = w_sel[1] ? w_lit : (w_sel[0] ? w_a : w_b);
   // Unary groups: sel[0] picks source, sel[1] picks destination.
   assign w_u = w_sel[0] ? w_b : w_a;

   always_comb begin
      w_res  = '0;
      w_we_a = 1'b0;
      w_we_b = 1'b0;
      case (w_grp)
         5'd0: w_res = w_y;
         5'd1: w_res = w_x + w_y;
         5'd2: w_res = w_x - w_y;
         5'd3: w_res = w_x & w_y;
         5'd4: w_res = w_x | w_y;
         5'd5: w_res = w_x ^ w_y;
         5'd6: w_res = ~w_u;
         5'd7: w_res = {w_u[DATA_W-2:0], 1'b0};
         5'd8: w_res = {1'b0, w_u[DATA_W-1:1]};
         default: w_res = '0;
      endcase
      if (w_grp <= 5'd5) begin
         w_we_a = ~w_sel[0];
         w_we_b = w_sel[0];
      end else if (w_grp <= 5'd8) begin
         w_we_a = ~w_sel[1];
         w_we_b = w_sel[1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= '0;
      end else begin
         r_pc <= r_pc + 1'b1;
      end
   end

   assign a_out  = w_a;
   assign b_out  = w_b;
   assign pc_out = r_pc;

endmodule

// File: tb/tb_computer.sv
// Directed bench for computer: programs are written into IM.mem, then stepped one edge at a time.

module tb_computer;

   logic       clk;
   logic       rst_n;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic [7:0] pc_out;

   int n_tests;
   int n_fail;

   computer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_out  (a_out),
      .b_out  (b_out),
      .pc_out (pc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] ins(input logic [6:0] op, input logic [7:0] lit);
      return {op, lit};
   endfunction

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) dut.IM.mem[i] = ins(7'h7F, 8'h00);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [23:0] exp;
      fill_nop();
      rst_n = 1'b0;
      step();
      step();
      n_tests++;
      if ({a_out, b_out, pc_out} !== 24'h000000) begin
         n_fail++;
         $display("FAIL reset: got A/B/PC=%h required %h", {a_out, b_out, pc_out}, 24'h0);
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         step();
         exp = {8'h00, 8'h00, 8'(k)};
         n_tests++;
         if ({a_out, b_out, pc_out} !== exp) begin
            n_fail++;
            $display("FAIL reset_count%0d: got %h required %h", k, {a_out, b_out, pc_out}, exp);
         end
      end
   endtask

   task automatic test_mov_add_shl();
      logic [23:0] exp [0:6];
      rst_n = 1'b0;
      fill_nop();
      dut.IM.mem[0] = ins(7'h02, 8'd42);
      dut.IM.mem[1] = ins(7'h03, 8'd123);
      dut.IM.mem[2] = ins(7'h02, 8'd2);
      dut.IM.mem[3] = ins(7'h03, 8'd3);
      dut.IM.mem[4] = ins(7'h04, 8'h00);
      dut.IM.mem[5] = ins(7'h02, 8'd5);
      dut.IM.mem[6] = ins(7'h1C, 8'h00);
      exp[0] = {8'd42, 8'd0,   8'd1};
      exp[1] = {8'd42, 8'd123, 8'd2};
      exp[2] = {8'd2,  8'd123, 8'd3};
      exp[3] = {8'd2,  8'd3,   8'd4};
      exp[4] = {8'd5,  8'd3,   8'd5};
      exp[5] = {8'd5,  8'd3,   8'd6};
      exp[6] = {8'd10, 8'd3,   8'd7};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         step();
         n_tests++;
         if ({a_out, b_out, pc_out} !== exp[k]) begin
            n_fail++;
            $display("FAIL mov_add_shl step%0d: got %h required %h", k, {a_out, b_out, pc_out},
                     exp[k]);
         end
      end
   endtask

   task automatic test_wrap_shift();
      logic [7:0] exp_a [0:6];
      rst_n = 1'b0;
      fill_nop();
      dut.IM.mem[0] = ins(7'h02, 8'h00);
      dut.IM.mem[1] = ins(7'h0A, 8'h01);
      dut.IM.mem[2] = ins(7'h06, 8'h01);
      dut.IM.mem[3] = ins(7'h02, 8'h81);
      dut.IM.mem[4] = ins(7'h1C, 8'h00);
      dut.IM.mem[5] = ins(7'h02, 8'h81);
      dut.IM.mem[6] = ins(7'h20, 8'h00);
      exp_a = '{8'h00, 8'hFF, 8'h00, 8'h81, 8'h02, 8'h81, 8'h40};
      do_reset();
      for (int k = 0; k < 7; k++) begin
         step();
         n_tests++;
         if ({a_out, b_out} !== {exp_a[k], 8'h00}) begin
            n_fail++;
            $display("FAIL wrap_shift step%0d: got A/B=%h required %h", k, {a_out, b_out},
                     {exp_a[k], 8'h00});
         end
      end
   endtask

   task automatic test_logic_ops();
      logic [15:0] exp [0:8];
      rst_n = 1'b0;
      fill_nop();
      dut.IM.mem[0] = ins(7'h03, 8'hF0); // MOV B,L
      dut.IM.mem[1] = ins(7'h02, 8'h3C); // MOV A,L
      dut.IM.mem[2] = ins(7'h0C, 8'h00); // AND A,B
      dut.IM.mem[3] = ins(7'h11, 8'h00); // OR B,A
      dut.IM.mem[4] = ins(7'h16, 8'hFF); // XOR A,L
      dut.IM.mem[5] = ins(7'h1A, 8'h00); // B <- NOT A
      dut.IM.mem[6] = ins(7'h09, 8'h00); // SUB B,A
      dut.IM.mem[7] = ins(7'h23, 8'h00); // B <- SHR B
      dut.IM.mem[8] = ins(7'h40, 8'h55); // unused opcode
      exp = '{16'h00F0, 16'h3CF0, 16'h30F0, 16'h30F0, 16'hCFF0, 16'hCF30, 16'hCF61,
              16'hCF30, 16'hCF30};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         step();
         n_tests++;
         if ({a_out, b_out} !== exp[k]) begin
            n_fail++;
            $display("FAIL logic_ops step%0d: got A/B=%h required %h", k, {a_out, b_out},
                     exp[k]);
         end
      end
   endtask

   task automatic test_pc_wrap_midreset();
      rst_n = 1'b0;
      fill_nop();
      do_reset();
      for (int k = 0; k < 255; k++) step();
      n_tests++;
      if (pc_out !== 8'd255) begin
         n_fail++;
         $display("FAIL pc_255: got %0d required 255", pc_out);
      end
      step();
      n_tests++;
      if (pc_out !== 8'd0) begin
         n_fail++;
         $display("FAIL pc_wrap: got %0d required 0", pc_out);
      end
      rst_n = 1'b0;
      dut.IM.mem[0] = ins(7'h02, 8'hAA);
      dut.IM.mem[1] = ins(7'h03, 8'h55);
      dut.IM.mem[7] = ins(7'h02, 8'h11);
      do_reset();
      for (int k = 0; k < 7; k++) step();
      n_tests++;
      if ({a_out, b_out, pc_out} !== {8'hAA, 8'h55, 8'd7}) begin
         n_fail++;
         $display("FAIL pre_midreset: got %h required %h", {a_out, b_out, pc_out},
                  {8'hAA, 8'h55, 8'd7});
      end
      rst_n = 1'b0;
      step();
      n_tests++;
      if ({a_out, b_out, pc_out} !== 24'h000000) begin
         n_fail++;
         $display("FAIL midreset: got %h required %h", {a_out, b_out, pc_out}, 24'h0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      test_reset();
      test_mov_add_shl();
      test_wrap_shift();
      test_logic_ops();
      test_pc_wrap_midreset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
